vect_serializer: RTL

- Unpacks a packed vector register value into a stream of scalar elements, one element per cycle.
- It is the consumer-side counterpart of the vector pipeline registers. It sits between the vector execute/writeback stage and scalar-width consumers such as the memory store port and debug trace.
- Uses valid/ready handshakes on both sides.
- Carries a side-band tag (for example, the instruction word or destination address) with every element.

---
 rtl/vect_serializer.sv | 78 +++++++
 1 files changed

// File: rtl/vect_serializer.sv
// vect_serializer: unpacks a packed vector into one element per cycle, valid/ready on both sides.
// Optional VECT_SERIALIZER_MASK_SKIP_EN: in_mask selects which elements are emitted.
module vect_serializer #(
    parameter int registerSize = 8,
    parameter int vectorSize = 4,
    parameter int WIDTH = 8,
    localparam int IW = vectorSize > 1 ? $clog2(vectorSize) : 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [vectorSize-1:0][registerSize-1:0]   in_vect,
    input  logic [WIDTH-1:0]                          in_tag,
`ifdef VECT_SERIALIZER_MASK_SKIP_EN
    input  logic [vectorSize-1:0]                     in_mask,
`endif
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [registerSize-1:0]                   out_elem,
    output logic [IW-1:0]                             out_idx,
    output logic                                      out_last,
    output logic [WIDTH-1:0]                          out_tag,
    output logic                                      busy
);
    localparam logic [0:0] IDLE = 1'b0, SEND = 1'b1;
    logic [0:0] state;
    logic [vectorSize-1:0][registerSize-1:0] vbuf;
    logic [WIDTH-1:0] tag;
    logic [IW-1:0] idx, first, nxt;
    logic last;
    logic [vectorSize-1:0] mask_q, new_mask;
`ifdef VECT_SERIALIZER_MASK_SKIP_EN
    assign new_mask = in_mask;
    always_ff @(posedge clk or posedge reset)
        if (reset) mask_q <= '0;
        else if (in_valid && in_ready) mask_q <= in_mask;
`else
    assign new_mask = '1;
    assign mask_q = '1;
`endif
    // Lowest set bit of the incoming mask, and next set bit above idx in the held mask.
    always_comb begin
        first = '0;
        nxt = idx;
        last = 1'b1;
        for (int i = vectorSize - 1; i >= 0; i--) begin
            if (new_mask[i]) first = IW'(i);
            if (mask_q[i] && IW'(i) > idx) begin
                nxt = IW'(i);
                last = 1'b0;
            end
        end
    end
    assign busy = state == SEND;
    assign out_valid = busy;
    assign out_last = busy & last;
    assign in_ready = !busy | (out_ready & last);
    assign out_elem = vbuf[idx];
    assign out_idx = idx;
    assign out_tag = tag;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            vbuf <= '0;
            tag <= '0;
            idx <= '0;
        end else if (in_valid && in_ready) begin
            vbuf <= in_vect;
            tag <= in_tag;
            idx <= first;
            state <= |new_mask ? SEND : IDLE;
        end else if (busy && out_ready) begin
            idx <= nxt;
            if (last) state <= IDLE;
        end
    end
endmodule
